// File: rtl/rvdff_rr_arb4.sv
// rvdff_rr_arb4: four-requester round-robin arbiter feeding a single output
// register with valid/ready handshakes, flush, and synchronous reset.
module rvdff_rr_arb4 #(
   parameter int WIDTH = 17
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [3:0]         req_valid,
   input  logic [4*WIDTH-1:0] req_data,
   output logic [3:0]         req_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [1:0]         out_src,
   input  logic               out_ready
);

   localparam int NUM_LANES = 4;

   logic [1:0]       ptr;
   logic [1:0]       win_idx;
   logic [1:0]       idx;
   logic             win_found;
   logic             load;
   logic             grant;
   logic [WIDTH-1:0] win_data;

   // Output register is free, or its contents leave this cycle; flush blocks refill.
   assign load  = ~flush & (~out_valid | out_ready);
   // Reset suppresses handshakes so no requester believes it was accepted.
   assign grant = ~rst & load & win_found;

   // Circular search from ptr; the 2-bit add wraps 3 -> 0 naturally.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr;
      idx       = ptr;
      for (int k = 0; k < NUM_LANES; k++) begin
         idx = ptr + 2'(k);
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_idx   = idx;
         end
      end
   end

   // One-hot ready on the winner plus the matching payload select.
   always_comb begin
      req_ready = '0;
      win_data  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (win_idx == 2'(i)) begin
            req_ready[i] = grant;
            win_data     = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Output register and pointer: reset > flush > load (fill or drain-to-empty) > hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         ptr       <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid <= win_found;
         if (win_found) begin
            out_data <= win_data;
            out_src  <= win_idx;
            ptr      <= win_idx + 2'd1;
         end
      end
   end

endmodule
